// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package pc_seq_pkg;

  localparam int unsigned DEF_D        = 12;
  localparam int unsigned DEF_S        = 4;
  localparam int unsigned DEF_START_PC = 0;
  localparam int unsigned DEF_HALT_PC  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FLOW_SEQ  = 3'd0,
    FLOW_REL  = 3'd1,
    FLOW_ABS  = 3'd2,
    FLOW_CALL = 3'd3,
    FLOW_RET  = 3'd4
  } flow_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Bounded LIFO of return addresses; pop wins over push, clear empties it.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned D = DEF_D,
  parameter int unsigned S = DEF_S
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] top_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned CW = $clog2(S + 1);
  localparam int unsigned AW = (S > 1) ? $clog2(S) : 1;

  logic [D-1:0]  mem [S];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full_c  = (cnt_q == CW'(S));
  assign empty_c = (cnt_q == '0);
  assign wr_idx  = AW'(cnt_q);
  assign rd_idx  = AW'(cnt_q - CW'(1));
  assign top_c   = mem[rd_idx];
  assign do_pop  = !clear && pop && !empty_c;
  assign do_push = !clear && !pop && push && !full_c;

  // Occupancy counter; the entry array itself needs no reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (do_pop) begin
      cnt_q <= cnt_q - CW'(1);
    end else if (do_push) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and run control: req/done handshake, prioritised flow, return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D        = DEF_D,
  parameter int unsigned S        = DEF_S,
  parameter int unsigned START_PC = DEF_START_PC,
  parameter int unsigned HALT_PC  = DEF_HALT_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         stall,
  input  logic         br_rel,
  input  logic         br_abs,
  input  logic         call,
  input  logic         ret,
  input  logic         zero_q,
  input  logic [D-1:0] target,
  input  logic [D-1:0] offset,
  output logic [D-1:0] prog_ctr,
  output logic         busy,
  output logic         done,
  output logic         fault
);

  state_e       state_q, state_d;
  flow_e        flow;
  logic [D-1:0] pc_q, pc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         fault_q, fault_d;
  logic         start;
  logic         halt_hit;
  logic         stk_push, stk_pop, stk_clear;
  logic [D-1:0] stk_top;
  logic         stk_full, stk_empty;

  assign start    = (state_q == ST_IDLE) && req;
  assign halt_hit = (pc_q == D'(HALT_PC));

  // Control priority: ret > call > br_abs > taken br_rel > sequential.
  always_comb begin
    flow = FLOW_SEQ;
    if (ret)                 flow = FLOW_RET;
    else if (call)           flow = FLOW_CALL;
    else if (br_abs)         flow = FLOW_ABS;
    else if (br_rel && zero_q) flow = FLOW_REL;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= D'(START_PC);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = ST_RUN;
      ST_RUN: begin
        if (!stall) begin
          if (halt_hit) begin
            state_d = ST_DONE;
          end else if (flow == FLOW_RET && stk_empty) begin
            state_d = ST_FAULT;
          end else if (flow == FLOW_CALL && stk_full) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_DONE, ST_FAULT: if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // PC update, stack strobes and next flag values; a faulting step leaves PC unchanged.
  always_comb begin
    pc_d     = pc_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    if (start) begin
      pc_d = D'(START_PC);
    end else if (state_q == ST_RUN && !stall && !halt_hit) begin
      unique case (flow)
        FLOW_RET: begin
          if (!stk_empty) begin
            stk_pop = 1'b1;
            pc_d    = stk_top;
          end
        end
        FLOW_CALL: begin
          if (!stk_full) begin
            stk_push = 1'b1;
            pc_d     = target;
          end
        end
        FLOW_ABS: pc_d = target;
        FLOW_REL: pc_d = pc_q + offset;
        default:  pc_d = pc_q + D'(1);
      endcase
    end
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE) || (state_d == ST_FAULT);
    fault_d = (state_d == ST_FAULT);
  end

  assign stk_clear = !reset || start;

  ret_stack #(
    .D(D),
    .S(S)
  ) u_ret_stack (
    .clk    (clk),
    .clear  (stk_clear),
    .push   (stk_push),
    .pop    (stk_pop),
    .din    (pc_q + D'(1)),
    .top_c  (stk_top),
    .full_c (stk_full),
    .empty_c(stk_empty)
  );

  assign prog_ctr = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboarded random and directed bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam int unsigned D        = 12;
  localparam int unsigned S        = 2;
  localparam int unsigned START_PC = 0;
  localparam int unsigned HALT_PC  = 15;

  typedef struct packed {
    logic [D-1:0] pc;
    logic         busy;
    logic         done;
    logic         fault;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, req, stall, br_rel, br_abs, call, ret, zero_q;
  logic [D-1:0] target, offset;
  logic [D-1:0] prog_ctr;
  logic         busy, done, fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t exp_q[$];

  // Behavioural model: plain flags, a queue as the stack, 12-bit wrapping PC.
  logic [D-1:0] m_pc = D'(START_PC);
  logic         m_running = 1'b0;
  logic         m_finished = 1'b0;
  logic         m_faulted = 1'b0;
  logic [D-1:0] m_stack[$];

  pc_sequencer #(
    .D(D), .S(S), .START_PC(START_PC), .HALT_PC(HALT_PC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .br_rel(br_rel),
    .br_abs(br_abs), .call(call), .ret(ret), .zero_q(zero_q), .target(target),
    .offset(offset), .prog_ctr(prog_ctr), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic end_with_fault();
    m_running  = 1'b0;
    m_finished = 1'b1;
    m_faulted  = 1'b1;
  endtask

  task automatic model_step();
    if (!reset) begin
      m_running = 1'b0; m_finished = 1'b0; m_faulted = 1'b0;
      m_pc = D'(START_PC);
      m_stack.delete();
    end else if (m_finished) begin
      if (!req) begin m_finished = 1'b0; m_faulted = 1'b0; end
    end else if (!m_running) begin
      if (req) begin
        m_running = 1'b1;
        m_pc = D'(START_PC);
        m_stack.delete();
      end
    end else if (!stall) begin
      if (m_pc == D'(HALT_PC)) begin
        m_running = 1'b0; m_finished = 1'b1;
      end else if (ret) begin
        if (m_stack.size() == 0) end_with_fault();
        else m_pc = m_stack.pop_back();
      end else if (call) begin
        if (m_stack.size() == S) end_with_fault();
        else begin m_stack.push_back(m_pc + D'(1)); m_pc = target; end
      end else if (br_abs) begin
        m_pc = target;
      end else if (br_rel && zero_q) begin
        m_pc = m_pc + offset;
      end else begin
        m_pc = m_pc + D'(1);
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected post-edge outputs.
  task automatic drive(input logic rs, input logic rq, input logic st, input logic brr,
                       input logic bra, input logic cl, input logic rt, input logic z,
                       input logic [D-1:0] tg, input logic [D-1:0] of);
    exp_t e;
    @(negedge clk);
    reset = rs; req = rq; stall = st; br_rel = brr; br_abs = bra;
    call = cl; ret = rt; zero_q = z; target = tg; offset = of;
    model_step();
    e.pc = m_pc; e.busy = m_running; e.done = m_finished; e.fault = m_faulted;
    exp_q.push_back(e);
  endtask

  task automatic seq_steps(input int n);
    for (int i = 0; i < n; i++) drive(1, 1, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic do_call(input logic [D-1:0] t);
    drive(1, 1, 0, 0, 0, 1, 0, 0, t, '0);
  endtask

  task automatic do_ret();
    drive(1, 1, 0, 0, 0, 0, 1, 0, '0, '0);
  endtask

  task automatic do_jump(input logic [D-1:0] t);
    drive(1, 1, 0, 0, 1, 0, 0, 0, t, '0);
  endtask

  // Monitor: outputs are valid every cycle; compare one queued expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (prog_ctr !== e.pc || busy !== e.busy || done !== e.done || fault !== e.fault) begin
          failures++;
          $display("FAIL scoreboard cyc=%0d got pc=%03h busy=%b done=%b fault=%b want pc=%03h busy=%b done=%b fault=%b",
                   cyc, prog_ctr, busy, done, fault, e.pc, e.busy, e.done, e.fault);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; req = 1'b0; stall = 1'b0; br_rel = 1'b0; br_abs = 1'b0;
    call = 1'b0; ret = 1'b0; zero_q = 1'b0; target = '0; offset = '0;

    // Reset, then a plain sequential run to HALT_PC and release.
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, '0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, '0, '0);
    idle(1);
    seq_steps(20);
    idle(2);

    // Relative branch taken (5 -> 3) and not taken (5 -> 6).
    seq_steps(6);
    drive(1, 1, 0, 1, 0, 0, 0, 1, '0, 12'hFFE);
    seq_steps(2);
    drive(1, 1, 0, 1, 0, 0, 0, 0, '0, 12'hFFE);
    seq_steps(12);
    idle(2);

    // Nested call/ret with S=2, then overflow on a third nested call.
    seq_steps(3);
    do_call(12'h100);
    do_call(12'h200);
    do_ret();
    do_ret();
    do_call(12'h100);
    do_call(12'h200);
    do_call(12'h300);
    seq_steps(3);
    idle(2);

    // Stall at 0xFFF, then wrap to 0 and run to halt.
    seq_steps(1);
    do_jump(12'hFFF);
    drive(1, 1, 1, 0, 0, 0, 0, 0, '0, '0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, '0, '0);
    drive(1, 1, 1, 0, 0, 0, 0, 0, '0, '0);
    seq_steps(19);
    idle(2);

    // Ret on an empty stack faults.
    seq_steps(1);
    do_ret();
    seq_steps(2);
    idle(2);

    // Reset asserted mid-stall at PC 7.
    seq_steps(8);
    drive(1, 1, 1, 0, 0, 0, 0, 0, '0, '0);
    drive(0, 1, 1, 0, 0, 0, 0, 0, '0, '0);
    idle(2);

    // Simultaneous call+ret pops 0x050 and ignores the call; next ret then faults.
    seq_steps(1);
    do_jump(12'h04F);
    do_call(12'h070);
    drive(1, 1, 0, 0, 0, 1, 1, 0, 12'h123, '0);
    do_ret();
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic rs, rq, st, brr, bra, cl, rt, z;
      logic [D-1:0] tg, of;
      rs  = ($urandom_range(0, 199) != 0);
      rq  = ($urandom_range(0, 19) != 0);
      st  = ($urandom_range(0, 3) == 0);
      brr = ($urandom_range(0, 5) == 0);
      bra = ($urandom_range(0, 9) == 0);
      cl  = ($urandom_range(0, 7) == 0);
      rt  = ($urandom_range(0, 7) == 0);
      z   = 1'($urandom_range(0, 1));
      tg  = ($urandom_range(0, 1) != 0) ? D'($urandom_range(0, 20)) : D'($urandom);
      of  = ($urandom_range(0, 1) != 0) ? D'($urandom_range(0, 6) - 3) : D'($urandom);
      drive(rs, rq, st, brr, bra, cl, rt, z, tg, of);
    end
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
